// File: rtl/uart_rx_ascii.sv
// UART 8N1 receiver with oversampled mid-bit sampling and a valid/ack holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with a Parity_error pulse output.
module uart_rx_ascii #(
    parameter int CLOCK_HZ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       Clock_100MHz,
    input  logic       Reset,
    input  logic       RxD,
    output logic [7:0] Data,
    output logic       Data_valid,
    input  logic       Data_ack,
    output logic       Framing_error,
    output logic       Overrun,
`ifdef UART_RX_PARITY_EN
    output logic       Parity_error,
`endif
    output logic       Busy
);

    localparam int DIV = CLOCK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t          state;
    logic            rx_meta, rxs;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [SW-1:0]   s;
    logic [2:0]      b;
    logic [7:0]      shreg;
    logic            frame_ok;

    // Synchronizer resets to the idle line level so reset release cannot fake a start edge.
    always_ff @(posedge Clock_100MHz or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge Clock_100MHz or posedge Reset) begin
        if (Reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_ok;
    assign parity_ok = ~^{shreg, par_bit};
`else
    logic parity_ok;
    assign parity_ok = 1'b1;
`endif
    assign frame_ok = rxs && parity_ok;
    assign Busy     = (state != IDLE);

    always_ff @(posedge Clock_100MHz or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            s             <= '0;
            b             <= '0;
            shreg         <= '0;
            Data          <= '0;
            Data_valid    <= 1'b0;
            Framing_error <= 1'b0;
            Overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            Parity_error  <= 1'b0;
`endif
        end else begin
            Framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Parity_error  <= 1'b0;
`endif
            if (Data_valid && Data_ack) begin
                Data_valid <= 1'b0;
                Overrun    <= 1'b0;
            end
            case (state)
                IDLE: if (!rxs) begin
                    state <= START;
                    s     <= '0;
                end
                START: if (tick) begin
                    if (s == S_MID) begin
                        if (rxs) state <= IDLE;
                        else begin
                            state <= DATA;
                            s     <= '0;
                            b     <= '0;
                        end
                    end else s <= s + 1'b1;
                end
                DATA: if (tick) begin
                    if (s == S_LAST) begin
                        shreg <= {rxs, shreg[7:1]};
                        s     <= '0;
                        b     <= b + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (b == 3'd7) state <= PARITY;
`else
                        if (b == 3'd7) state <= STOP;
`endif
                    end else s <= s + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    if (s == S_LAST) begin
                        par_bit <= rxs;
                        s       <= '0;
                        state   <= STOP;
                    end else s <= s + 1'b1;
                end
`endif
                STOP: if (tick) begin
                    if (s == S_LAST) begin
                        s             <= '0;
                        Framing_error <= !rxs;
`ifdef UART_RX_PARITY_EN
                        Parity_error  <= !parity_ok;
`endif
                        if (frame_ok) begin
                            // A simultaneous ack frees the register, so no overrun in that case.
                            Data       <= shreg;
                            Data_valid <= 1'b1;
                            Overrun    <= Data_valid && !Data_ack;
                        end
                        state <= rxs ? IDLE : BRK;
                    end else s <= s + 1'b1;
                end
                BRK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Directed bench for uart_rx_ascii at DIV=10 (160 clocks per bit).
module tb_uart_rx_ascii;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       dvalid;
    logic       dack;
    logic       ferr;
    logic       ovr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
    int         pe_cnt = 0;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int fe_cnt = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic dv_q = 1'b0;
    logic busy_mid;

    uart_rx_ascii #(.CLOCK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
        .Clock_100MHz (clk),
        .Reset        (rst),
        .RxD          (rxd),
        .Data         (data),
        .Data_valid   (dvalid),
        .Data_ack     (dack),
        .Framing_error(ferr),
        .Overrun      (ovr),
`ifdef UART_RX_PARITY_EN
        .Parity_error (perr),
`endif
        .Busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ferr) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (perr) pe_cnt <= pe_cnt + 1;
`endif
        if (dvalid && !dv_q) rise_cyc <= cyc;
        dv_q <= dvalid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line is left at the stop-bit level when the task returns.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        rxd = 1'b0;
        start_cyc = cyc;
        clks(160);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (i == 4) busy_mid = busy;
            clks(160);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        clks(160);
`else
        if (par) busy_mid = busy_mid;
`endif
        rxd = stop;
        clks(160);
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic ack();
        dack = 1'b1;
        clks(1);
        dack = 1'b0;
    endtask

    initial begin
        int fe0;
        int lat;
        logic [7:0] d;
        rst = 1'b1; rxd = 1'b1; dack = 1'b0;
        clks(3);
        chk("rst_data",  {24'd0, data}, 32'h0);
        chk("rst_valid", {31'd0, dvalid}, 32'h0);
        chk("rst_ovr",   {31'd0, ovr}, 32'h0);
        chk("rst_busy",  {31'd0, busy}, 32'h0);
        rst = 1'b0;
        clks(50);

        // 1: single good byte, latency bound
        send(8'h41);
        lat = rise_cyc - start_cyc;
        chk("t1_data",  {24'd0, data}, 32'h41);
        chk("t1_valid", {31'd0, dvalid}, 32'h1);
        chk("t1_busy_mid", {31'd0, busy_mid}, 32'h1);
        chk("t1_fe", fe_cnt, 0);
        chk("t1_lat_max", {31'd0, lat <= 1533}, 32'h1);
        chk("t1_lat_min", {31'd0, lat >= 1510}, 32'h1);
        ack();
        chk("t1_ack_valid", {31'd0, dvalid}, 32'h0);
        clks(20);

        // 2: overrun then ack clears both flags
        send(8'h0D);
        send(8'h0A);
        chk("t2_data",  {24'd0, data}, 32'h0A);
        chk("t2_ovr",   {31'd0, ovr}, 32'h1);
        chk("t2_valid", {31'd0, dvalid}, 32'h1);
        ack();
        chk("t2_ack_valid", {31'd0, dvalid}, 32'h0);
        chk("t2_ack_ovr",   {31'd0, ovr}, 32'h0);
        clks(20);

        // 3: framing error, held-low line, recovery
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        clks(480);
        chk("t3_fe_pulses", fe_cnt - fe0, 1);
        chk("t3_valid", {31'd0, dvalid}, 32'h0);
        chk("t3_data_kept", {24'd0, data}, 32'h0A);
        chk("t3_busy_brk", {31'd0, busy}, 32'h1);
        rxd = 1'b1;
        clks(5);
        chk("t3_busy_idle", {31'd0, busy}, 32'h0);
        clks(100);
        send(8'h31);
        chk("t3_data", {24'd0, data}, 32'h31);
        chk("t3_valid2", {31'd0, dvalid}, 32'h1);
        ack();
        clks(20);

        // 4: short glitch rejected
        fe0 = fe_cnt;
        rxd = 1'b0;
        clks(30);
        chk("t4_busy_start", {31'd0, busy}, 32'h1);
        clks(30);
        rxd = 1'b1;
        clks(300);
        chk("t4_valid", {31'd0, dvalid}, 32'h0);
        chk("t4_fe", fe_cnt - fe0, 0);
        chk("t4_busy", {31'd0, busy}, 32'h0);

        // 5: reset mid-frame
        d = 8'h7E;
        rxd = 1'b0;
        clks(160);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            clks(160);
        end
        rxd = d[4];
        clks(80);
        chk("t5_busy_pre", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_data", {24'd0, data}, 32'h0);
        chk("t5_busy", {31'd0, busy}, 32'h0);
        chk("t5_valid", {31'd0, dvalid}, 32'h0);
        chk("t5_ovr", {31'd0, ovr}, 32'h0);
        rxd = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(200);
        chk("t5_idle_busy", {31'd0, busy}, 32'h0);
        send(8'h39);
        chk("t5_data2", {24'd0, data}, 32'h39);
        chk("t5_valid2", {31'd0, dvalid}, 32'h1);
        ack();
        clks(20);

`ifdef UART_RX_PARITY_EN
        // 6: even parity good and bad
        send_frame(8'h41, 1'b1, 1'b0);
        chk("t6_good_data", {24'd0, data}, 32'h41);
        chk("t6_good_valid", {31'd0, dvalid}, 32'h1);
        chk("t6_good_pe", pe_cnt, 0);
        ack();
        clks(20);
        send_frame(8'h41, 1'b1, 1'b1);
        chk("t6_bad_pe", pe_cnt, 1);
        chk("t6_bad_valid", {31'd0, dvalid}, 32'h0);
        clks(20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
